// File: rtl/cva5_config.sv
// Core configuration: branch predictor sizing and checkpoint capacity.
package cva5_config;

    typedef struct packed {
        int unsigned RAS_ENTRIES;
    } branch_predictor_config_t;

    typedef struct packed {
        branch_predictor_config_t BP;
    } cpu_config_t;

    localparam cpu_config_t EXAMPLE_CONFIG = '{BP: '{RAS_ENTRIES: 4}};

    // Number of branch checkpoints that may be in flight at once.
    localparam int unsigned MAX_IDS = 8;

endpackage

// File: rtl/cva5_types.sv
// Shared type definitions for the fetch-stage control logic.
package cva5_types;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        RECOVER
    } ras_ctrl_state_t;

endpackage

// File: rtl/cva5_fifo.sv
// Small synchronous FIFO; head entry is visible on data_out while valid.
// Reset is synchronous so a same-cycle flush can still read the head entry.
module cva5_fifo #(
    parameter type DATA_TYPE = logic,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  DATA_TYPE data_in,
    output DATA_TYPE data_out,
    output logic     valid
);
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    DATA_TYPE           r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign valid    = (r_count != '0);
    assign data_out = r_mem[r_rd_ptr];
    assign w_push   = push & (r_count != CNT_W'(FIFO_DEPTH));
    assign w_pop    = pop & valid;

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage write; contents need no reset since valid gates them
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= data_in;
    end

endmodule

// File: rtl/ras_ctrl.sv
// Return address stack sequencing: turns fetch decode and back-end events into
// RAS push/pop/checkpoint strobes, tracking stack depth and in-flight checkpoints.
module ras_ctrl
    import cva5_config::*;
    import cva5_types::*;
#(
    parameter cpu_config_t CONFIG = EXAMPLE_CONFIG
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic        is_call,
    input  logic        is_return,
    input  logic        is_branch,
    input  logic [31:0] call_return_addr,
    input  logic        branch_retired,
    input  logic        fetch_flush,
    input  logic        early_branch_flush,
    output logic        ras_push,
    output logic        ras_pop,
    output logic [31:0] ras_new_addr,
    output logic        ras_branch_fetched,
    output logic        ras_branch_retired,
    output logic        return_valid,
    output logic        fetch_hold
);
    localparam int unsigned DEPTH_W = $clog2(CONFIG.BP.RAS_ENTRIES + 1);
    localparam int unsigned OUT_W   = $clog2(MAX_IDS + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(CONFIG.BP.RAS_ENTRIES);
    localparam logic [OUT_W-1:0]   OUT_MAX   = OUT_W'(MAX_IDS);

    ras_ctrl_state_t        r_state;
    logic [DEPTH_W-1:0]     r_depth;
    logic [OUT_W-1:0]       r_outstanding;

    logic                   w_flush;
    logic                   w_ckpt_full;
    logic                   w_fetch_en;
    logic                   w_fifo_rst;
    logic                   w_ckpt_valid;
    logic [DEPTH_W-1:0]     w_ckpt_depth;

    assign w_flush     = fetch_flush | early_branch_flush;
    assign w_ckpt_full = (r_outstanding == OUT_MAX);
    assign fetch_hold  = (r_state != RUN) | w_flush | w_ckpt_full;

    // A held fetch is not accepted, so none of its decode strobes may reach the RAS
    assign w_fetch_en         = fetch_valid & ~fetch_hold;
    assign ras_push           = w_fetch_en & is_call;
    assign ras_pop            = w_fetch_en & is_return & (r_depth != '0);
    assign ras_branch_fetched = w_fetch_en & is_branch;
    assign ras_branch_retired = branch_retired & (r_outstanding != '0);
    assign ras_new_addr       = call_return_addr;
    assign return_valid       = (r_depth != '0) & (r_state == RUN);

    // Controller state: one settle cycle after reset and after every flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= INIT;
        end else begin
            unique case (r_state)
                INIT:    r_state <= RUN;
                RUN:     r_state <= w_flush ? RECOVER : RUN;
                RECOVER: r_state <= w_flush ? RECOVER : RUN;
                default: r_state <= INIT;
            endcase
        end
    end

    // In-flight checkpoint count, mirrors the checkpoint FIFO occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
        end else if (w_flush) begin
            r_outstanding <= '0;
        end else if (ras_branch_fetched && !ras_branch_retired) begin
            r_outstanding <= r_outstanding + 1'b1;
        end else if (ras_branch_retired && !ras_branch_fetched) begin
            r_outstanding <= r_outstanding - 1'b1;
        end
    end

    // Valid stack depth; a full stack rolls over so depth saturates
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_depth <= '0;
        end else if (fetch_flush) begin
            if (w_ckpt_valid)
                r_depth <= w_ckpt_depth;
        end else if (early_branch_flush) begin
            r_depth <= r_depth;
        end else if (ras_push && !ras_pop) begin
            if (r_depth != DEPTH_MAX)
                r_depth <= r_depth + 1'b1;
        end else if (ras_pop && !ras_push) begin
            r_depth <= r_depth - 1'b1;
        end
    end

    assign w_fifo_rst = rst | w_flush;

    cva5_fifo #(
        .DATA_TYPE  (logic [DEPTH_W-1:0]),
        .FIFO_DEPTH (MAX_IDS)
    ) u_depth_ckpt (
        .clk      (clk),
        .rst      (w_fifo_rst),
        .push     (ras_branch_fetched),
        .pop      (ras_branch_retired),
        .data_in  (r_depth),
        .data_out (w_ckpt_depth),
        .valid    (w_ckpt_valid)
    );

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl with RAS_ENTRIES=4 and MAX_IDS=8.
module tb_ras_ctrl;
    import cva5_config::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_valid, is_call, is_return, is_branch;
    logic [31:0] call_return_addr;
    logic        branch_retired, fetch_flush, early_branch_flush;
    logic        ras_push, ras_pop, ras_branch_fetched, ras_branch_retired;
    logic        return_valid, fetch_hold;
    logic [31:0] ras_new_addr;
    logic [5:0]  w_obs;

    int n_checks = 0;
    int n_errors = 0;

    // Control word: {fetch_valid, is_call, is_return, is_branch, branch_retired,
    //                fetch_flush, early_branch_flush}
    localparam logic [6:0] IDLE   = 7'b0000000;
    localparam logic [6:0] CALL   = 7'b1100000;
    localparam logic [6:0] RET    = 7'b1010000;
    localparam logic [6:0] CORO   = 7'b1110000;
    localparam logic [6:0] BR     = 7'b1001000;
    localparam logic [6:0] RETIRE = 7'b0000100;
    localparam logic [6:0] FFL    = 7'b0000010;
    localparam logic [6:0] EFL    = 7'b0000001;

    always #5 clk = ~clk;

    ras_ctrl #(
        .CONFIG (EXAMPLE_CONFIG)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .fetch_valid        (fetch_valid),
        .is_call            (is_call),
        .is_return          (is_return),
        .is_branch          (is_branch),
        .call_return_addr   (call_return_addr),
        .branch_retired     (branch_retired),
        .fetch_flush        (fetch_flush),
        .early_branch_flush (early_branch_flush),
        .ras_push           (ras_push),
        .ras_pop            (ras_pop),
        .ras_new_addr       (ras_new_addr),
        .ras_branch_fetched (ras_branch_fetched),
        .ras_branch_retired (ras_branch_retired),
        .return_valid       (return_valid),
        .fetch_hold         (fetch_hold)
    );

    // Observed vector: {push, pop, branch_fetched, branch_retired, return_valid, hold}
    assign w_obs = {ras_push, ras_pop, ras_branch_fetched, ras_branch_retired,
                    return_valid, fetch_hold};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs after the falling edge and check combinational outputs
    task automatic step(input string tag, input logic [6:0] ctl, input logic [5:0] exp);
        @(negedge clk);
        {fetch_valid, is_call, is_return, is_branch, branch_retired,
         fetch_flush, early_branch_flush} = ctl;
        #1;
        check(tag, 32'(w_obs), 32'(exp));
    endtask

    initial begin
        rst = 1'b1;
        {fetch_valid, is_call, is_return, is_branch, branch_retired,
         fetch_flush, early_branch_flush} = IDLE;
        call_return_addr = 32'h0;

        // Reset and the single INIT cycle
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset", 32'(w_obs), 32'(6'b000001));
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("init_hold", 32'(w_obs), 32'(6'b000001));
        step("ret_empty", RET, 6'b000000);

        // Five calls saturate depth at 4, then four pops and a suppressed fifth
        for (int i = 0; i < 5; i++) begin
            call_return_addr = 32'h100 + 32'(4 * i);
            step($sformatf("call%0d", i), CALL, {1'b1, 3'b000, (i != 0), 1'b0});
            check($sformatf("call_addr%0d", i), ras_new_addr, 32'h100 + 32'(4 * i));
        end
        for (int i = 0; i < 4; i++)
            step($sformatf("ret_pop%0d", i), RET, 6'b010010);
        step("ret_underflow", RET, 6'b000000);

        // Co-routine: call then call+return keeps depth at 1
        step("coro_call", CALL, 6'b100000);
        step("coro_both", CORO, 6'b110010);
        step("coro_ret", RET, 6'b010010);
        step("coro_empty", RET, 6'b000000);

        // Fill all checkpoints, then release one
        for (int i = 0; i < 8; i++)
            step($sformatf("br%0d", i), BR, 6'b001000);
        step("br_full", BR, 6'b000001);
        step("retire_full", RETIRE, 6'b000101);
        step("hold_release", IDLE, 6'b000000);
        step("flush_a", FFL, 6'b000001);
        step("recover_a", IDLE, 6'b000001);
        step("run_a", IDLE, 6'b000000);
        step("retire_cleared", RETIRE, 6'b000000);

        // Checkpoint at depth 2, grow to 4, flush restores 2
        step("ck_call0", CALL, 6'b100000);
        step("ck_call1", CALL, 6'b100010);
        step("ck_branch", BR, 6'b001010);
        step("ck_call2", CALL, 6'b100010);
        step("ck_call3", CALL, 6'b100010);
        step("flush_b", FFL | CALL, 6'b000011);
        step("recover_b", CALL, 6'b000001);
        step("restored_pop0", RET | RETIRE, 6'b010010);
        step("restored_pop1", RET, 6'b010010);
        step("restored_empty", RET, 6'b000000);

        // Early flush clears checkpoints but keeps depth
        step("ef_call", CALL, 6'b100000);
        for (int i = 0; i < 3; i++)
            step($sformatf("ef_br%0d", i), BR, 6'b001010);
        step("eflush", EFL, 6'b000011);
        step("recover_c", IDLE, 6'b000001);
        step("retire_after_ef", RETIRE, 6'b000010);
        step("ef_call2", CALL, 6'b100010);
        step("flush_empty_fifo", FFL, 6'b000011);
        step("recover_d", IDLE, 6'b000001);
        step("hold_pop0", RET, 6'b010010);
        step("hold_pop1", RET, 6'b010010);
        step("hold_empty", RET, 6'b000000);

        // Asynchronous reset mid-cycle forces reset outputs at once
        step("pre_rst_call", CALL, 6'b100000);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 32'(w_obs), 32'(6'b000001));
        @(negedge clk);
        {fetch_valid, is_call, is_return, is_branch, branch_retired,
         fetch_flush, early_branch_flush} = IDLE;
        rst = 1'b0;
        #1;
        check("post_rst_init", 32'(w_obs), 32'(6'b000001));
        step("post_rst_ret", RET, 6'b000000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Sequencing controller for the fetch-stage return address stack. It turns per-cycle fetch decode information (call, return, speculative branch) and back-end events (retire, flush) into the stack's push/pop/checkpoint strobes. It tracks outstanding checkpoints so the pointer-checkpoint FIFO never overflows, and tracks valid stack depth so returns from an empty stack are not predicted. It sits between the fetch predecode logic and the RAS, driving its input interface.

## Interface
- CONFIG, EXAMPLE_CONFIG: cpu_config_t; CONFIG.BP.RAS_ENTRIES sets the depth range.
- MAX_IDS (package constant, not a parameter): checkpoint capacity.
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- fetch_valid  in  1  fetch block accepted this cycle
- is_call  in  1  fetched instruction is a call (link write)
- is_return  in  1  fetched instruction is a return
- is_branch  in  1  fetched instruction is speculative control flow needing a checkpoint
- call_return_addr  in  32  return address for a call (PC+2/+4)
- branch_retired  in  1  oldest checkpointed branch retired
- fetch_flush  in  1  gc.fetch_flush
- early_branch_flush  in  1  early_branch_flush_ras_adjust
- ras_push  out  1  RAS push strobe
- ras_pop  out  1  RAS pop strobe
- ras_new_addr  out  32  data for push
- ras_branch_fetched  out  1  checkpoint enqueue
- ras_branch_retired  out  1  checkpoint dequeue
- return_valid  out  1  RAS output address is a usable prediction
- fetch_hold  out  1  fetch must not accept a new block this cycle

## Operation
- FSM states: INIT, RUN, RECOVER.
  - Reset enters INIT. INIT moves to RUN after 1 cycle.
  - In RUN, fetch_flush or early_branch_flush moves to RECOVER. RECOVER moves to RUN after 1 cycle.
  - A flush arriving in RECOVER re-enters RECOVER.
- Strobes in RUN without a flush:
  - ras_push = fetch_valid & is_call.
  - ras_pop = fetch_valid & is_return & (depth != 0).
  - ras_branch_fetched = fetch_valid & is_branch.
- Call and return together (co-routine): both strobes assert in the same cycle.
- ras_new_addr = call_return_addr, passed through combinationally.
- The fetch-derived strobes are masked to 0 when any of these hold: the state is INIT or RECOVER, fetch_flush is high, or early_branch_flush is high.
- Outstanding counter (width $clog2(MAX_IDS+1)):
  - Increments on ras_branch_fetched.
  - Decrements on ras_branch_retired.
  - ras_branch_retired = branch_retired & (outstanding != 0).
  - Simultaneous increment and decrement leaves it unchanged.
  - Cleared on fetch_flush or early_branch_flush.
- fetch_hold = (state != RUN) | fetch_flush | early_branch_flush | (outstanding == MAX_IDS).
- Depth counter (width $clog2(RAS_ENTRIES+1)) update rules:
  - Push-only: depth+1, saturating at RAS_ENTRIES (the stack rolls over).
  - Pop-only: depth−1.
  - Push with pop: unchanged.
- return_valid = (depth != 0) & (state == RUN).
- Depth checkpoint FIFO (depth MAX_IDS) behaviour:
  - Pushes the current depth on ras_branch_fetched.
  - Pops on ras_branch_retired.
  - On fetch_flush, depth restores to the oldest checkpoint if the FIFO is non-empty, otherwise it holds.
  - The FIFO is then cleared.
  - early_branch_flush clears the FIFO without changing depth.
- Event priority: rst > fetch_flush > early_branch_flush > normal update.

## Timing
- Reset values:
  - state = INIT; depth = 0; outstanding = 0.
  - ras_push, ras_pop, ras_branch_fetched, ras_branch_retired and return_valid are all 0.
  - fetch_hold = 1.
- All strobes are combinational from same-cycle inputs and registered state. Counters and state update on posedge clk.
- A flush in cycle N masks strobes in N and N+1 (RECOVER), and holds fetch in both. Strobes are re-enabled in N+2.
- An async reset asserted mid-operation forces the reset values immediately. The first RUN cycle is the second rising edge after deassertion.
- Checkpoint full: when outstanding == MAX_IDS, fetch_hold is high. A retire in that cycle lowers fetch_hold in the next cycle.

## Structure
- Package cva5_types holds ras_ctrl_state_t (INIT/RUN/RECOVER).
- MAX_IDS and cpu_config_t come from cva5_config.
- One sub-module: cva5_fifo instance (DATA_TYPE logic[$clog2(RAS_ENTRIES+1)-1:0], FIFO_DEPTH MAX_IDS) for depth checkpoints. Its reset is rst | fetch_flush | early_branch_flush.
- Expected size: ~200 lines of RTL.

## Test plan
- Reset with RAS_ENTRIES=4: outputs at reset values, fetch_hold=1 for 1 cycle. Then an is_return fetch gives ras_pop=0 and return_valid=0.
- 5 calls (addrs 0x100..0x110): ras_push=1 each cycle with ras_new_addr matching, and depth saturates at 4. Then 4 returns give ras_pop=1 each. The 5th return gives ras_pop=0.
- Co-routine sequence: call then call+return in the same cycle. Both strobes assert in the second cycle and depth stays 1 across it.
- With MAX_IDS=8, 8 branches with no retire: fetch_hold=1 after the 8th and the 9th is not strobed. One retire gives fetch_hold=0 the next cycle.
- Depth 2 and branch fetched (checkpoint=2), then 2 calls (depth 4), then fetch_flush: depth=2, no strobes for 2 cycles, outstanding=0.
- early_branch_flush with 3 outstanding: outstanding=0, depth unchanged. A later branch_retired gives ras_branch_retired=0.
